// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the WISC pipeline sequencer.
// State encodings, scoreboard sizing and the control bundle type.
package hazard_ctrl_pkg;

    localparam int NREG  = 8;
    localparam int CNT_W = 2;
    localparam int REG_W = $clog2(NREG);
    localparam int OCC_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_en;
        logic issue;
    } ctrl_t;

    // Free-running pipe: everything enabled, nothing squashed, nothing issued.
    localparam ctrl_t CTRL_RESET = '{
        pc_en:      1'b1,
        ifid_en:    1'b1,
        ifid_flush: 1'b0,
        idex_flush: 1'b0,
        exmem_en:   1'b1,
        issue:      1'b0
    };

    localparam ctrl_t CTRL_OFF = '0;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// reg_scoreboard: per-register pending-write counters.
// Saturating inc/dec with an over/underflow pulse and a nonzero vector.
module reg_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic [REG_W-1:0] inc_reg_i,
    input  logic             dec_i,
    input  logic [REG_W-1:0] dec_reg_i,
    output logic [NREG-1:0]  pend_nz_o,
    output logic             all_clear_o,
    output logic             fault_o
);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  up;
    logic [NREG-1:0]  dn;
    logic [NREG-1:0]  ovf;
    logic [NREG-1:0]  unf;

    // Next count per register; a same-register inc/dec pair cancels.
    always_comb begin
        up        = '0;
        dn        = '0;
        ovf       = '0;
        unf       = '0;
        pend_nz_o = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r]     = cnt_q[r];
            up[r]        = inc_i && (inc_reg_i == REG_W'(r));
            dn[r]        = dec_i && (dec_reg_i == REG_W'(r));
            pend_nz_o[r] = |cnt_q[r];
            if (up[r] && !dn[r]) begin
                if (cnt_q[r] == CNT_MAX) begin
                    ovf[r] = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end
            end else if (dn[r] && !up[r]) begin
                if (cnt_q[r] == '0) begin
                    unf[r] = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    assign all_clear_o = ~|pend_nz_o;
    assign fault_o     = |(ovf | unf);

    // Counter array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: WISC 5-stage sequencer (RAW stall, squash, freeze, drain).
// Build option: define HAZARD_FWD_EN for forwarding with load-use stalls only.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_wr_en,
    input  logic [2:0] id_wr_reg,
    input  logic       id_is_load,
    input  logic       id_is_halt,
    input  logic       ex_redirect,
    input  logic       mem_busy,
    input  logic       wb_wr_en,
    input  logic [2:0] wb_wr_reg,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       issue,
    output logic       halted,
    output logic       err
);

    state_e           state_q;
    logic             halted_q;
    logic             err_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [NREG-1:0]  pend_nz;
    logic             all_clear;
    logic             sb_fault;
    logic             haz;
    logic             issue_nh;
    logic             sb_inc;
    ctrl_t            ctrl;

`ifdef HAZARD_FWD_EN
    logic             ex_load_q;
    logic [REG_W-1:0] ex_dst_q;

    // Only a load sitting in EX cannot be forwarded in time.
    always_comb begin
        haz = id_valid && ex_load_q &&
              ((id_rs_used && (id_rs == ex_dst_q)) ||
               (id_rt_used && (id_rt == ex_dst_q)));
    end

    // EX-stage load tracker: follows issue, bubbles clear it, freeze holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_load_q <= 1'b0;
            ex_dst_q  <= '0;
        end else if (!mem_busy) begin
            ex_load_q <= issue_nh && id_is_load;
            ex_dst_q  <= issue_nh ? id_wr_reg : '0;
        end
    end
`else
    // Any pending write to a used source blocks decode.
    always_comb begin
        haz = id_valid &&
              ((id_rs_used && pend_nz[id_rs]) ||
               (id_rt_used && pend_nz[id_rt]));
    end
`endif

    // Per-cycle control, highest priority first: freeze, squash, stall, issue.
    always_comb begin
        ctrl = CTRL_RESET;
        if (rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        ctrl.pc_en    = 1'b0;
                        ctrl.ifid_en  = 1'b0;
                        ctrl.exmem_en = 1'b0;
                    end else if (ex_redirect) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (haz) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else begin
                        ctrl.issue = id_valid;
                    end
                end
                ST_DRAIN: begin
                    ctrl.pc_en   = 1'b0;
                    ctrl.ifid_en = 1'b0;
                    if (mem_busy) begin
                        ctrl.exmem_en = 1'b0;
                    end else begin
                        ctrl.idex_flush = 1'b1;
                    end
                end
                default: begin
                    ctrl = CTRL_OFF;
                end
            endcase
        end
    end

    assign issue_nh = ctrl.issue && !id_is_halt;
    assign sb_inc   = issue_nh && id_wr_en;

    reg_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst),
        .inc_i       (sb_inc),
        .inc_reg_i   (id_wr_reg),
        .dec_i       (wb_wr_en),
        .dec_reg_i   (wb_wr_reg),
        .pend_nz_o   (pend_nz),
        .all_clear_o (all_clear),
        .fault_o     (sb_fault)
    );

    // Occupancy shift EX->MEM->WB; on freeze WB empties, EX and MEM hold.
    always_comb begin
        if (mem_busy) begin
            occ_d = {1'b0, occ_q[1], occ_q[0]};
        end else begin
            occ_d = {occ_q[1], occ_q[0], issue_nh};
        end
    end

    // Occupancy storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Sequencer FSM with registered halted/err flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (sb_fault) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_RUN: begin
                    if (ctrl.issue && id_is_halt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((occ_q == '0) && all_clear) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_en   = ctrl.exmem_en;
    assign issue      = ctrl.issue;
    assign halted     = halted_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Reference model tracks in-flight instructions as a list and counts per register.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wr_en;
    logic [2:0] id_wr_reg;
    logic       id_is_load;
    logic       id_is_halt;
    logic       ex_redirect;
    logic       mem_busy;
    logic       wb_wr_en;
    logic [2:0] wb_wr_reg;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_en;
    logic       issue;
    logic       halted;
    logic       err;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_is_load  (id_is_load),
        .id_is_halt  (id_is_halt),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_reg   (wb_wr_reg),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .issue       (issue),
        .halted      (halted),
        .err         (err)
    );

    logic [7:0] dut_out;
    assign dut_out = {pc_en, ifid_en, ifid_flush, idex_flush,
                      exmem_en, issue, halted, err};

    // ---------------- reference model ----------------
    typedef struct {
        int stage;  // 0=EX 1=MEM 2=WB
        bit wr;
        int rd;
        bit ld;
    } fl_t;

    fl_t        pipe[$];
    int         pend[8];
    int         mode;   // 0 running, 1 draining, 2 halted
    bit         err_m;
    bit         wb_auto;
    logic [7:0] expq[$];
    int         checks = 0;
    int         errors = 0;

    function automatic void model_reset();
        for (int r = 0; r < 8; r++) pend[r] = 0;
        mode  = 0;
        err_m = 1'b0;
        pipe.delete();
    endfunction

    function automatic bit model_haz();
`ifdef HAZARD_FWD_EN
        foreach (pipe[i]) begin
            if (pipe[i].stage == 0 && pipe[i].ld &&
                ((id_rs_used && int'(id_rs) == pipe[i].rd) ||
                 (id_rt_used && int'(id_rt) == pipe[i].rd)))
                return id_valid;
        end
        return 1'b0;
`else
        return id_valid &&
               ((id_rs_used && pend[id_rs] > 0) ||
                (id_rt_used && pend[id_rt] > 0));
`endif
    endfunction

    function automatic logic [7:0] model_out();
        bit pc = 1, fi = 1, ff = 0, xf = 0, xm = 1, is = 0;
        if (rst) begin
            if (mode == 2) begin
                pc = 0; fi = 0; xm = 0;
            end else if (mem_busy) begin
                pc = 0; fi = 0; xm = 0;
            end else if (mode == 1) begin
                pc = 0; fi = 0; xf = 1;
            end else if (ex_redirect) begin
                ff = 1; xf = 1;
            end else if (model_haz()) begin
                pc = 0; fi = 0; xf = 1;
            end else begin
                is = id_valid;
            end
        end
        return {pc, fi, ff, xf, xm, is, rst && mode == 2, rst && err_m};
    endfunction

    function automatic void model_update(logic [7:0] e);
        bit   iss;
        bit   inc;
        bit   empty;
        bit   clr;
        fl_t  nxt[$];
        fl_t  n;
        if (!rst) begin
            model_reset();
            return;
        end
        iss   = e[2];
        inc   = iss && id_wr_en && !id_is_halt;
        empty = (pipe.size() == 0);
        clr   = 1'b1;
        for (int r = 0; r < 8; r++) if (pend[r] != 0) clr = 1'b0;
        if (!(inc && wb_wr_en && id_wr_reg == wb_wr_reg)) begin
            if (inc) begin
                if (pend[id_wr_reg] == 3) err_m = 1'b1;
                else pend[id_wr_reg]++;
            end
            if (wb_wr_en) begin
                if (pend[wb_wr_reg] == 0) err_m = 1'b1;
                else pend[wb_wr_reg]--;
            end
        end
        foreach (pipe[i]) begin
            n = pipe[i];
            if (mem_busy) begin
                if (n.stage < 2) nxt.push_back(n);
            end else begin
                n.stage++;
                if (n.stage <= 2) nxt.push_back(n);
            end
        end
        if (iss && !id_is_halt) begin
            n.stage = 0;
            n.wr    = id_wr_en;
            n.rd    = int'(id_wr_reg);
            n.ld    = id_is_load;
            nxt.push_back(n);
        end
        pipe = nxt;
        if (mode == 0 && iss && id_is_halt) mode = 1;
        else if (mode == 1 && empty && clr) mode = 2;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        id_valid    = 0; id_rs = 0; id_rt = 0;
        id_rs_used  = 0; id_rt_used = 0;
        id_wr_en    = 0; id_wr_reg = 0;
        id_is_load  = 0; id_is_halt = 0;
        ex_redirect = 0; mem_busy = 0;
        wb_wr_en    = 0; wb_wr_reg = 0;
    endtask

    task automatic rand_in();
        id_valid    = ($urandom_range(0, 4) != 0);
        id_rs       = 3'($urandom_range(0, 7));
        id_rt       = 3'($urandom_range(0, 7));
        id_rs_used  = 1'($urandom_range(0, 1));
        id_rt_used  = 1'($urandom_range(0, 1));
        id_wr_en    = 1'($urandom_range(0, 1));
        id_wr_reg   = 3'($urandom_range(0, 7));
        id_is_load  = id_wr_en && ($urandom_range(0, 2) == 0);
        id_is_halt  = ($urandom_range(0, 40) == 0);
        if (id_is_halt) begin
            id_wr_en   = 0;
            id_is_load = 0;
        end
        ex_redirect = ($urandom_range(0, 7) == 0);
        mem_busy    = ($urandom_range(0, 7) == 0);
        wb_wr_en    = 1'($urandom_range(0, 1));
        wb_wr_reg   = 3'($urandom_range(0, 7));
    endtask

    task automatic wr_instr(input int rd, input bit ld);
        clear_in();
        id_valid   = 1;
        id_wr_en   = 1;
        id_wr_reg  = 3'(rd);
        id_is_load = ld;
    endtask

    task automatic rd_instr(input int rs);
        clear_in();
        id_valid   = 1;
        id_rs      = 3'(rs);
        id_rs_used = 1;
    endtask

    // One cycle: inputs already set at posedge+1; queue expectation, advance model.
    task automatic step();
        logic [7:0] e;
        if (wb_auto) begin
            wb_wr_en  = 0;
            wb_wr_reg = 0;
            foreach (pipe[i]) begin
                if (pipe[i].stage == 2 && pipe[i].wr) begin
                    wb_wr_en  = 1;
                    wb_wr_reg = 3'(pipe[i].rd);
                end
            end
        end
        e = model_out();
        expq.push_back(e);
        @(posedge clk);
        model_update(e);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic [7:0] mon_e;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checks++;
            if (dut_out !== mon_e) begin
                errors++;
                $display("FAIL ctrl t=%0t got pc,ifid,iff,idf,exm,iss,hlt,err=%b want %b",
                         $time, dut_out, mon_e);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        clear_in();
        rst     = 0;
        wb_auto = 1;
        model_reset();
        @(posedge clk);
        #1;

        // reset held with random inputs
        repeat (4) begin
            rand_in();
            step();
        end
        rst = 1;
        clear_in();
        id_valid = 1;
        step();

        // RAW on R3 stalls until its writeback
        wr_instr(3, 0);
        step();
        rd_instr(3);
        repeat (6) step();

        // redirect beats hazard and HALT
        wr_instr(1, 0);
        step();
        rd_instr(1);
        id_is_halt  = 1;
        ex_redirect = 1;
        step();
        clear_in();
        repeat (4) step();

        // memory freeze with writers in flight
        wr_instr(4, 0);
        step();
        wr_instr(6, 0);
        step();
        wr_instr(7, 0);
        step();
        clear_in();
        id_valid = 1;
        mem_busy = 1;
        repeat (3) step();
        clear_in();
        repeat (4) step();

        // ALU and load producers feeding the next instruction
        wr_instr(1, 0);
        step();
        rd_instr(1);
        repeat (4) step();
        wr_instr(2, 1);
        step();
        rd_instr(2);
        repeat (4) step();
        clear_in();
        repeat (3) step();

        // same-register inc/dec cancels; then overflow R5
        wb_auto = 0;
        wr_instr(5, 0);
        step();
        wr_instr(5, 0);
        wb_wr_en  = 1;
        wb_wr_reg = 5;
        step();
        repeat (4) begin
            wr_instr(5, 0);
            step();
        end
        clear_in();
        repeat (2) step();
        rst = 0;
        step();
        rst = 1;
        // underflow
        clear_in();
        wb_wr_en  = 1;
        wb_wr_reg = 2;
        step();
        clear_in();
        step();
        rst = 0;
        step();
        rst = 1;
        wb_auto = 1;

        // HALT drains two writers
        wr_instr(2, 0);
        step();
        wr_instr(4, 0);
        step();
        clear_in();
        id_valid   = 1;
        id_is_halt = 1;
        step();
        clear_in();
        id_valid = 1;
        repeat (8) step();
        rst = 0;
        step();
        rst = 1;

        // random, pipeline-consistent writebacks, occasional mid-run reset
        repeat (500) begin
            rand_in();
            rst = ($urandom_range(0, 60) != 0);
            if (mode == 2 && $urandom_range(0, 3) == 0) rst = 0;
            step();
        end

        // random, free writebacks
        rst     = 1;
        wb_auto = 0;
        repeat (200) begin
            rand_in();
            rst = ($urandom_range(0, 30) != 0);
            step();
        end

        clear_in();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain expq left=%0d want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
